// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared constants and state encoding for the IF/ID skid buffer
package if_id_skid_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HEAD  = 2'd1,
    S_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID pipeline register with a 2-entry skid buffer and flush
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4
);

  skid_state_e state_q, state_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        enq, deq;

  // Ready/valid are pure decodes of the state register, so no input reaches them combinationally.
  assign if_ready = (state_q != S_FULL);
  assign id_valid = (state_q != S_EMPTY);
  assign enq      = if_valid & if_ready;
  assign deq      = id_valid & id_ready;

  assign id_pc   = head_pc_q;
  assign id_inst = head_inst_q;
  assign id_pc4  = head_pc_q + 32'd4;

  // Next-state and datapath: inputs are only captured on enq; head falls back to NOP when empty.
  always_comb begin
    state_d     = state_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    unique case (state_q)
      S_EMPTY: begin
        if (enq) begin
          state_d     = S_HEAD;
          head_pc_d   = if_pc;
          head_inst_d = if_inst;
        end
      end
      S_HEAD: begin
        if (enq && deq) begin
          head_pc_d   = if_pc;
          head_inst_d = if_inst;
        end else if (enq) begin
          state_d     = S_FULL;
          skid_pc_d   = if_pc;
          skid_inst_d = if_inst;
        end else if (deq) begin
          state_d     = S_EMPTY;
          head_pc_d   = RESET_PC;
          head_inst_d = NOP_INST;
        end
      end
      S_FULL: begin
        if (deq) begin
          state_d     = S_HEAD;
          head_pc_d   = skid_pc_q;
          head_inst_d = skid_inst_q;
        end
      end
      default: begin
        state_d     = S_EMPTY;
        head_pc_d   = RESET_PC;
        head_inst_d = NOP_INST;
      end
    endcase
    // Flush wins over any handshake: drop everything, including a same-cycle offer.
    if (flush) begin
      state_d     = S_EMPTY;
      head_pc_d   = RESET_PC;
      head_inst_d = NOP_INST;
    end
  end

  // State and storage registers; reset behaves as a flush that also clears the skid slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      head_pc_q   <= RESET_PC;
      head_inst_q <= NOP_INST;
      skid_pc_q   <= RESET_PC;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed self-checking bench for if_id_skid
module tb_if_id_skid;

  localparam logic [31:0] RPC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        flush;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;

  int vectors = 0;
  int miscompares = 0;

  if_id_skid dut (
    .clk      (clk),
    .rst      (rst),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .if_ready (if_ready),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_pc4   (id_pc4)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    offer(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid got=%0b exp=0", id_valid); end
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready got=%0b exp=1", if_ready); end
    vectors++; if (id_pc !== RPC) begin miscompares++; $display("FAIL reset_id_pc got=%h exp=%h", id_pc, RPC); end
    vectors++; if (id_inst !== NOP) begin miscompares++; $display("FAIL reset_id_inst got=%h exp=%h", id_inst, NOP); end
    vectors++; if (id_pc4 !== 32'h0) begin miscompares++; $display("FAIL reset_id_pc4 got=%h exp=0", id_pc4); end
    rst = 1'b0;
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    tick();
    vectors++; if (id_inst !== NOP) begin miscompares++; $display("FAIL idle_x_inst got=%h exp=%h", id_inst, NOP); end
  endtask

  task automatic test_streaming();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, pcs[i], 32'hA000_0000 + pcs[i]);
      tick();
      vectors++; if (id_valid !== 1'b1 || id_pc !== pcs[i]) begin miscompares++; $display("FAIL stream_pc%0d got v=%0b pc=%h exp v=1 pc=%h", i, id_valid, id_pc, pcs[i]); end
      vectors++; if (id_inst !== 32'hA000_0000 + pcs[i] || if_ready !== 1'b1) begin miscompares++; $display("FAIL stream_inst%0d got inst=%h rdy=%0b exp inst=%h rdy=1", i, id_inst, if_ready, 32'hA000_0000 + pcs[i]); end
    end
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    tick();
    vectors++; if (id_valid !== 1'b0 || id_pc !== RPC) begin miscompares++; $display("FAIL stream_drain got v=%0b pc=%h exp v=0 pc=%h", id_valid, id_pc, RPC); end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    offer(1'b1, 32'h0, 32'hB000_0000);
    tick();
    offer(1'b1, 32'h4, 32'hB000_0004);
    tick();
    vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL stall_full_ready got=%0b exp=0", if_ready); end
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin miscompares++; $display("FAIL stall_head got v=%0b pc=%h exp v=1 pc=0", id_valid, id_pc); end
    offer(1'b1, 32'hC, 32'hB000_000C);
    tick();
    vectors++; if (id_pc !== 32'h0 || if_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hold got pc=%h rdy=%0b exp pc=0 rdy=0", id_pc, if_ready); end
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    id_ready = 1'b1;
    tick();
    vectors++; if (id_pc !== 32'h4 || id_inst !== 32'hB000_0004 || id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_skid got v=%0b pc=%h inst=%h exp v=1 pc=4 inst=b0000004", id_valid, id_pc, id_inst); end
    vectors++; if (if_ready !== 1'b1) begin miscompares++; $display("FAIL stall_reopen got=%0b exp=1", if_ready); end
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL stall_empty got=%0b exp=0", id_valid); end
  endtask

  task automatic test_flush_full();
    id_ready = 1'b0;
    offer(1'b1, 32'h10, 32'hC000_0010);
    tick();
    offer(1'b1, 32'h14, 32'hC000_0014);
    tick();
    offer(1'b1, 32'h40, 32'hC000_0040);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    vectors++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin miscompares++; $display("FAIL flush_state got v=%0b rdy=%0b exp v=0 rdy=1", id_valid, if_ready); end
    vectors++; if (id_pc !== RPC || id_inst !== NOP) begin miscompares++; $display("FAIL flush_outputs got pc=%h inst=%h exp pc=%h inst=%h", id_pc, id_inst, RPC, NOP); end
    id_ready = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b0 || id_pc === 32'h40) begin miscompares++; $display("FAIL flush_drop got v=%0b pc=%h exp v=0 pc=%h", id_valid, id_pc, RPC); end
  endtask

  task automatic test_flush_then_offer();
    id_ready = 1'b0;
    offer(1'b1, 32'h20, 32'hD000_0020);
    tick();
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b1, 32'h80, 32'hD000_0080);
    tick();
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h80 || id_inst !== 32'hD000_0080) begin miscompares++; $display("FAIL refill got v=%0b pc=%h inst=%h exp v=1 pc=80 inst=d0000080", id_valid, id_pc, id_inst); end
    vectors++; if (id_pc4 !== 32'h84) begin miscompares++; $display("FAIL refill_pc4 got=%h exp=84", id_pc4); end
    id_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset_while_full();
    id_ready = 1'b0;
    offer(1'b1, 32'h30, 32'hE000_0030);
    tick();
    offer(1'b1, 32'h34, 32'hE000_0034);
    tick();
    vectors++; if (if_ready !== 1'b0) begin miscompares++; $display("FAIL prerst_full got rdy=%0b exp=0", if_ready); end
    rst = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin miscompares++; $display("FAIL rst_full_state got v=%0b rdy=%0b exp v=0 rdy=1", id_valid, if_ready); end
    vectors++; if (id_pc !== RPC || id_inst !== NOP || id_pc4 !== 32'h0) begin miscompares++; $display("FAIL rst_full_outputs got pc=%h inst=%h pc4=%h exp pc=%h inst=%h pc4=0", id_pc, id_inst, id_pc4, RPC, NOP); end
    rst = 1'b0;
    offer(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    id_ready = 1'b1;
    tick();
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_skid got v=%0b pc=%h exp v=0", id_valid, id_pc); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    test_reset();
    test_streaming();
    test_stall();
    test_flush_full();
    test_flush_then_offer();
    test_reset_while_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
